// File: rtl/cop_fetch_if.sv
// Fetch-side bus bundle: copper RAM read port plus the executor valid/ready stream.
// master = fetch stage, slave = RAM/executor side.
interface cop_fetch_if #(
   parameter int unsigned ADDRESS_WIDTH = 11,
   parameter int unsigned DATA_WIDTH    = 16
);
   logic [ADDRESS_WIDTH-1:0] ram_read_address;
   logic                     ram_read_en;
   logic [DATA_WIDTH-1:0]    ram_read_data;
   logic [DATA_WIDTH-1:0]    data;
   logic [ADDRESS_WIDTH-1:0] data_address;
   logic                     data_valid;
   logic                     data_ready;

   modport master (
      output ram_read_address,
      output ram_read_en,
      input  ram_read_data,
      output data,
      output data_address,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  ram_read_address,
      input  ram_read_en,
      output ram_read_data,
      input  data,
      input  data_address,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/cop_fetch.sv
// Copper instruction fetch: program counter, one-cycle-latency RAM reads and a
// prefetch FIFO feeding the executor; flushes on frame start and executor jumps.
module cop_fetch #(
   parameter int unsigned ADDRESS_WIDTH = 11,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     frame_start,
   input  logic [ADDRESS_WIDTH-1:0] start_address,
   input  logic                     jump_en,
   input  logic [ADDRESS_WIDTH-1:0] jump_address,
   cop_fetch_if.master              bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   logic [ADDRESS_WIDTH-1:0] pc;
   logic                     inflight;
   logic [ADDRESS_WIDTH-1:0] inflight_address;
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [CNT_W-1:0]         count;
   logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
   logic [ADDRESS_WIDTH-1:0] fifo_addr [FIFO_DEPTH];

   logic                     flush;
   logic                     pop;
   logic                     push;
   logic                     read_en;
   logic                     valid;
   logic [OCC_W-1:0]         occupancy;
   logic [ADDRESS_WIDTH-1:0] flush_target;

   // Reads are only issued when the word is guaranteed a free slot on return.
   always_comb begin
      flush        = frame_start | jump_en;
      valid        = (count != CNT_W'(0));
      pop          = valid & bus.data_ready;
      push         = inflight & ~flush;
      occupancy    = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
      read_en      = enable & ~flush & (occupancy < OCC_W'(FIFO_DEPTH));
      flush_target = frame_start ? start_address : jump_address;
   end

   // Program counter, in-flight tracking and FIFO bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc               <= '0;
         inflight         <= 1'b0;
         inflight_address <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
      end else if (flush) begin
         pc       <= flush_target;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= read_en;
         if (read_en) begin
            pc               <= pc + ADDRESS_WIDTH'(1);
            inflight_address <= pc;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_data[i] <= '0;
            fifo_addr[i] <= '0;
         end
      end else if (push) begin
         fifo_data[wr_ptr] <= bus.ram_read_data;
         fifo_addr[wr_ptr] <= inflight_address;
      end
   end

   assign bus.ram_read_address = pc;
   assign bus.ram_read_en      = read_en;
   assign bus.data             = fifo_data[rd_ptr];
   assign bus.data_address     = fifo_addr[rd_ptr];
   assign bus.data_valid       = valid;
endmodule

// File: tb/tb_cop_fetch.sv
// Bench for cop_fetch: cycle-exact vector table plus a scoreboard of expected
// fetch addresses for streaming, backpressure, jump and reset sequences.
module tb_cop_fetch;
   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        frame_start;
   logic [10:0] start_address;
   logic        jump_en;
   logic [10:0] jump_address;

   cop_fetch_if #(.ADDRESS_WIDTH(11), .DATA_WIDTH(16)) bus ();

   cop_fetch #(.ADDRESS_WIDTH(11), .DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .frame_start   (frame_start),
      .start_address (start_address),
      .jump_en       (jump_en),
      .jump_address  (jump_address),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM contents are a fixed function of the address, distinct from the address itself.
   function automatic logic [15:0] ram_word(input logic [10:0] a);
      return {a, 5'h16} ^ 16'h3C00;
   endfunction

   always @(posedge clk) begin
      if (bus.ram_read_en) bus.ram_read_data <= ram_word(bus.ram_read_address);
   end

   typedef struct {
      logic        en, fs, je, rdy;
      logic [10:0] sa, ja;
      logic        ren;
      logic [10:0] raddr;
      logic        dv;
      logic [10:0] daddr;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic fs, input logic [10:0] sa,
                               input logic je, input logic [10:0] ja, input logic rdy,
                               input logic ren, input logic [10:0] raddr,
                               input logic dv, input logic [10:0] daddr);
      vec_t v;
      v.en = en; v.fs = fs; v.sa = sa; v.je = je; v.ja = ja; v.rdy = rdy;
      v.ren = ren; v.raddr = raddr; v.dv = dv; v.daddr = daddr;
      return v;
   endfunction

   int          checks = 0;
   int          errors = 0;
   int          pops   = 0;
   logic        mon_on = 1'b0;
   logic [10:0] sb_q[$];
   logic        hold_v = 1'b0;
   logic [15:0] hold_d;
   logic [10:0] hold_a;
   vec_t        vt[24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_load(input logic [10:0] start, input int n);
      sb_q.delete();
      for (int k = 0; k < n; k++) sb_q.push_back(11'(start + 11'(k)));
   endtask

   // Scoreboard and hold-stability monitor, evaluated mid-cycle.
   task automatic mon();
      logic [10:0] e;
      if (mon_on && reset_n && !(frame_start || jump_en)) begin
         if (hold_v) begin
            chk("hold_valid", 32'(bus.data_valid), 32'd1);
            chk("hold_data", 32'(bus.data), 32'(hold_d));
            chk("hold_addr", 32'(bus.data_address), 32'(hold_a));
         end
         if (bus.data_valid && bus.data_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_extra: got word at %0h expected none", bus.data_address);
            end else begin
               e = sb_q.pop_front();
               chk("sb_addr", 32'(bus.data_address), 32'(e));
               chk("sb_data", 32'(bus.data), 32'(ram_word(e)));
            end
            pops++;
         end
         hold_v = bus.data_valid && !bus.data_ready;
         hold_d = bus.data;
         hold_a = bus.data_address;
      end else begin
         hold_v = 1'b0;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      mon();
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         settle();
         edge_step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = mk(1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 11'h000, 1'b0, 11'h000);
      vt[1]  = mk(1'b1, 1'b1, 11'h7FE, 1'b0, 11'h000, 1'b1, 1'b0, 11'h000, 1'b0, 11'h000);
      vt[2]  = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h7FE, 1'b0, 11'h000);
      vt[3]  = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h7FF, 1'b0, 11'h000);
      vt[4]  = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h000, 1'b1, 11'h7FE);
      vt[5]  = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h001, 1'b1, 11'h7FF);
      vt[6]  = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h002, 1'b1, 11'h000);
      vt[7]  = mk(1'b1, 1'b1, 11'h020, 1'b1, 11'h300, 1'b1, 1'b0, 11'h003, 1'b1, 11'h001);
      vt[8]  = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h020, 1'b0, 11'h000);
      vt[9]  = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h021, 1'b0, 11'h000);
      vt[10] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h022, 1'b1, 11'h020);
      vt[11] = mk(1'b1, 1'b0, 11'h000, 1'b1, 11'h100, 1'b1, 1'b0, 11'h023, 1'b1, 11'h021);
      vt[12] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h100, 1'b0, 11'h000);
      vt[13] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h101, 1'b0, 11'h000);
      vt[14] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h102, 1'b1, 11'h100);
      vt[15] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 11'h103, 1'b1, 11'h101);
      vt[16] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 11'h104, 1'b1, 11'h101);
      vt[17] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 11'h105, 1'b1, 11'h101);
      vt[18] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 11'h105, 1'b1, 11'h101);
      vt[19] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h105, 1'b1, 11'h101);
      vt[20] = mk(1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 11'h106, 1'b1, 11'h102);
      vt[21] = mk(1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 11'h107, 1'b1, 11'h103);
      vt[22] = mk(1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 11'h107, 1'b1, 11'h103);
      vt[23] = mk(1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 11'h107, 1'b1, 11'h104);

      reset_n = 1'b0; enable = 1'b0; frame_start = 1'b0; jump_en = 1'b0;
      start_address = 11'h000; jump_address = 11'h000; bus.data_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.data_valid), 32'd0);
      chk("rst_data", 32'(bus.data), 32'd0);
      chk("rst_daddr", 32'(bus.data_address), 32'd0);
      chk("rst_raddr", 32'(bus.ram_read_address), 32'd0);
      chk("rst_ren", 32'(bus.ram_read_en), 32'd0);
      reset_n = 1'b1;

      // Cycle-exact vectors: wrap, dual flush priority, jump, backpressure, enable low.
      for (int i = 0; i < 24; i++) begin
         edge_step();
         enable = vt[i].en; frame_start = vt[i].fs; start_address = vt[i].sa;
         jump_en = vt[i].je; jump_address = vt[i].ja; bus.data_ready = vt[i].rdy;
         settle();
         chk($sformatf("v%0d_ren", i), 32'(bus.ram_read_en), 32'(vt[i].ren));
         chk($sformatf("v%0d_raddr", i), 32'(bus.ram_read_address), 32'(vt[i].raddr));
         chk($sformatf("v%0d_valid", i), 32'(bus.data_valid), 32'(vt[i].dv));
         if (vt[i].dv) begin
            chk($sformatf("v%0d_daddr", i), 32'(bus.data_address), 32'(vt[i].daddr));
            chk($sformatf("v%0d_data", i), 32'(bus.data), 32'(ram_word(vt[i].daddr)));
         end
      end
      edge_step();

      // Sustained streaming from 0x010: one word per cycle after two-cycle latency.
      enable = 1'b1; frame_start = 1'b1; start_address = 11'h010; jump_en = 1'b0;
      bus.data_ready = 1'b1; mon_on = 1'b1; sb_load(11'h010, 64); pops = 0;
      run(1);
      frame_start = 1'b0;
      run(19);
      chk("stream_pops", 32'(pops), 32'd17);

      // Random backpressure and enable gaps across the address wrap.
      frame_start = 1'b1; start_address = 11'h7FD; sb_load(11'h7FD, 400); pops = 0;
      run(1);
      frame_start = 1'b0;
      for (int c = 0; c < 300; c++) begin
         bus.data_ready = 1'($urandom_range(0, 1));
         enable = ($urandom_range(0, 3) != 0);
         run(1);
      end
      enable = 1'b1; bus.data_ready = 1'b1;
      run(12);
      chk("random_progress", 32'(pops >= 50), 32'd1);

      // Jump while three words are buffered and a fourth is in flight.
      frame_start = 1'b1; start_address = 11'h040; bus.data_ready = 1'b0;
      sb_load(11'h040, 8); pops = 0;
      run(1);
      frame_start = 1'b0;
      run(4);
      jump_en = 1'b1; jump_address = 11'h100; sb_load(11'h100, 32); pops = 0;
      settle();
      chk("jmp_pre_valid", 32'(bus.data_valid), 32'd1);
      chk("jmp_pre_daddr", 32'(bus.data_address), 32'h040);
      chk("jmp_pre_ren", 32'(bus.ram_read_en), 32'd0);
      edge_step();
      jump_en = 1'b0; bus.data_ready = 1'b1;
      run(11);
      chk("jmp_pops", 32'(pops), 32'd9);

      // Enable dropped with a read in flight, then asynchronous reset mid-cycle.
      mon_on = 1'b0;
      frame_start = 1'b1; start_address = 11'h200; bus.data_ready = 1'b0;
      run(1);
      frame_start = 1'b0;
      run(1);
      enable = 1'b0;
      settle();
      chk("dis_ren", 32'(bus.ram_read_en), 32'd0);
      chk("dis_raddr", 32'(bus.ram_read_address), 32'h201);
      chk("dis_valid0", 32'(bus.data_valid), 32'd0);
      edge_step();
      settle();
      chk("dis_land_valid", 32'(bus.data_valid), 32'd1);
      chk("dis_land_daddr", 32'(bus.data_address), 32'h200);
      chk("dis_land_data", 32'(bus.data), 32'(ram_word(11'h200)));
      edge_step();
      run(3);
      settle();
      chk("dis_hold_raddr", 32'(bus.ram_read_address), 32'h201);
      chk("dis_hold_valid", 32'(bus.data_valid), 32'd1);
      chk("dis_hold_ren", 32'(bus.ram_read_en), 32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.data_valid), 32'd0);
      chk("arst_raddr", 32'(bus.ram_read_address), 32'd0);
      chk("arst_ren", 32'(bus.ram_read_en), 32'd0);
      chk("arst_data", 32'(bus.data), 32'd0);
      chk("arst_daddr", 32'(bus.data_address), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      run(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cop_fetch.md
# cop_fetch

Instruction fetch stage for the copper, sitting directly downstream of the 2048×16 copper program RAM. It holds the copper program counter and issues one-cycle-latency reads into the RAM's read port. Returned words are buffered in a small prefetch FIFO and handed to the copper executor over a valid/ready handshake. It restarts at a programmable address on each frame start and redirects on executor jumps, discarding any stale prefetched words.

## Interface

Parameters:

- ADDRESS_WIDTH, 11, copper RAM word-address width
- DATA_WIDTH, 16, instruction word width
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2

Ports:

- clk  input  1  system clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  copper enabled; low suppresses new reads
- frame_start  input  1  single-cycle pulse: flush and restart at start_address
- start_address  input  ADDRESS_WIDTH  program entry point, sampled when frame_start is high
- jump_en  input  1  single-cycle pulse from executor: flush and redirect
- jump_address  input  ADDRESS_WIDTH  redirect target, sampled when jump_en is high
- ram_read_address  output  ADDRESS_WIDTH  to RAM read_address; equals pc register
- ram_read_en  output  1  to RAM read_en; combinational
- ram_read_data  input  DATA_WIDTH  from RAM read_data, valid the cycle after ram_read_en
- data  output  DATA_WIDTH  FIFO head word
- data_address  output  ADDRESS_WIDTH  RAM address the head word was fetched from
- data_valid  output  1  FIFO non-empty
- data_ready  input  1  executor accepts head; pop = data_valid && data_ready

## Operation

- State:
  - pc
  - inflight flag plus inflight_address
  - FIFO storage with read/write pointers and count (0..FIFO_DEPTH)
- flush = frame_start || jump_en. Priority: reset_n low > frame_start > jump_en > normal.
- On flush edge:
  - pc ← start_address (frame_start) or jump_address (jump_en only).
  - FIFO count ← 0, pointers ← 0.
  - inflight ← 0. A RAM word returning in the next cycle is discarded and never pushed.
- ram_read_en = enable && !flush && (count + inflight − pop < FIFO_DEPTH).
  - Reads are never issued beyond available space.
  - The FIFO never overflows.
- On an edge with ram_read_en high:
  - inflight ← 1, inflight_address ← pc.
  - pc ← pc + 1 modulo 2^ADDRESS_WIDTH; 2047 wraps to 0.
- On an edge with inflight high and no flush: push {ram_read_data, inflight_address} into the FIFO.
  - inflight ← ram_read_en of that cycle.
- Simultaneous push and pop: count unchanged. Push into a full FIFO is impossible by construction. A pop while empty is ignored.
- enable low: no new reads; an in-flight word still lands; FIFO contents and pc are retained. Raising enable resumes from pc.
- This block does not guard against write/read contention on the RAM. The writer side owns that.

## Timing

- Reset (async assert, sync-free release) sets:
  - pc = 0, inflight = 0, count = 0
  - data_valid = 0, data = 0, data_address = 0
  - ram_read_address = 0
  - ram_read_en = 0 while enable is low.
- Flush latency, with flush sampled at edge N:
  - ram_read_en high with address = target in cycle N→N+1.
  - RAM captures at N+1.
  - Push at N+2; data_valid high after N+2.
- Sustained throughput: one word per cycle with data_ready held high and enable high.
- Backpressure: with data_ready low, reads stop once count + inflight = FIFO_DEPTH. No word is lost or duplicated.
- data and data_address are stable while data_valid && !data_ready.
- Flush in the same cycle as a pop: the pop is irrelevant; the FIFO is empty after the edge.
- frame_start and jump_en both high: frame_start wins; jump_address is ignored.

## Test plan

- Reset, then enable=1, frame_start pulse with start_address=0x010, data_ready=1, RAM[i]=i → data_valid rises 2 cycles after the pulse. Words 0x010, 0x011, 0x012… are delivered on consecutive cycles, with data_address matching.
- start_address=0x7FE, free-running → addresses 0x7FE, 0x7FF, 0x000, 0x001 are delivered in order, showing wrap.
- data_ready=0 for 10 cycles after start → count saturates at 4 and ram_read_en stays low. On release, 4 buffered words plus new fetches arrive with no gap, loss, or duplicate.
- jump_en with jump_address=0x100 while FIFO holds 3 words and a read is in flight → next delivered word is RAM[0x100] at data_address 0x100. No pre-jump words appear.
- frame_start and jump_en asserted together (start_address=0x020, jump_address=0x300) → first delivered word comes from 0x020.
- enable dropped mid-stream, then reset_n pulsed low asynchronously mid-cycle → the in-flight word lands and pc holds. On reset, data_valid=0 and ram_read_address=0 immediately.
